train_sequencer: RTL
====================

Name: train_sequencer

Overview:
- Upstream controller for the 2-3-1 perceptron training datapath.
- Stores a small training set: input pairs plus targets.
- On start, streams samples into the input layer as a/b, drives target and step to the output-layer backprop stage, and pulses update once per sample after a fixed forward-settle time.
- Repeats the sample set for a programmed number of epochs, then signals done.

Parameters:
- DEPTH, 4, number of sample slots in the internal sample buffer.
- AW, 2, address width of the sample buffer (log2 DEPTH).
- LAT, 4, number of clock cycles a sample is held before update; covers forward settle plus backprop settle. Legal values are 1 or more.
- EPOCH_W, 16, width of the epoch count and epoch counter.

Ports:
- clk, in, 1, clock. All state updates on the rising edge; the layers sample on the falling edge.
- reset, in, 1, synchronous active-low reset.
- wr_en, in, 1, sample-buffer write strobe.
- wr_addr, in, AW, sample slot to write.
- wr_a, in, 32, input 1 value for that slot.
- wr_b, in, 32, input 2 value for that slot.
- wr_target, in, 32, target value for that slot.
- n_samples, in, AW+1, number of samples per epoch.
- n_epochs, in, EPOCH_W, number of epochs to run.
- step_in, in, 32, learning step (same fixed-point format as arith).
- start, in, 1, single-cycle pulse that starts a run.
- a, out, 32, input 1 presented to the input layer.
- b, out, 32, input 2 presented to the input layer.
- target, out, 32, target presented to the output-layer backprop stage.
- step, out, 32, learning step, latched at start.
- update, out, 1, weight-update strobe, high for 1 cycle per sample.
- busy, out, 1, high while a run is in progress.
- done, out, 1, high for 1 cycle when a run completes.
- sample_idx, out, AW, index of the sample currently presented.
- epoch_cnt, out, EPOCH_W, number of completed epochs.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - a, b, target, step, sample_idx, epoch_cnt, update, busy, done and the settle counter all go to 0.
  - The sample buffer is not cleared.
  - Reset mid-run aborts immediately and produces no done pulse.
- Sample buffer writes:
  - When wr_en is high and state is IDLE, mem[wr_addr] <= {wr_a, wr_b, wr_target}.
  - wr_en is ignored when not IDLE.
- Run configuration:
  - start is honoured only in IDLE and ignored otherwise.
  - n_samples is clamped to DEPTH and latched at start as N; n_epochs is latched as E; step_in is latched into step.
  - If N==0 or E==0, done pulses on the next cycle, busy stays 0, and state stays IDLE.
- States: IDLE, LOAD, SETTLE, UPDATE, DONE.
- IDLE -> LOAD on a valid start:
  - busy <= 1, sample_idx <= 0, epoch_cnt <= 0.
- LOAD (1 cycle):
  - a, b, target <= mem[sample_idx].
  - Settle counter <= LAT-1, then go to SETTLE.
  - If LAT==1, go directly to UPDATE.
- SETTLE:
  - Decrement the counter; on 0 go to UPDATE.
  - a, b and target stay constant.
- UPDATE (1 cycle):
  - update is a registered output, high exactly in this cycle.
  - If sample_idx==N-1: sample_idx <= 0 and epoch_cnt++. If the new epoch_cnt equals E, go to DONE; otherwise go to LOAD.
  - Otherwise sample_idx++ and go to LOAD.
- DONE (1 cycle):
  - done=1, busy <= 0, then IDLE.
  - a, b, target and step hold their last values.
  - epoch_cnt holds E until the next start.
- Timing, for start sampled at edge k:
  - First sample appears at edge k+1.
  - update is high from edge k+LAT+1 to edge k+LAT+2.
  - Sample period is LAT+1 cycles.
  - done is high from edge k+1+N*E*(LAT+1) for 1 cycle.
- Counters never wrap within a run, because epoch_cnt stops at E.

Decomposition:
- Shared package holds:
  - data width constant DW=32;
  - state encoding (IDLE=0, LOAD=1, SETTLE=2, UPDATE=3, DONE=4, 3 bits);
  - the sample record layout (a in bits 95:64, b in 63:32, target in 31:0).
- One natural sub-module: sample_mem, a DEPTH x 96 register file with a synchronous write port and a combinational read port. It has no reset.

Test Plan:
- Basic run: write slot0 = {0x00010000, 0x00020000, 0x00008000} and slot1 = {0x00030000, 0x00040000, 0}. Set n_samples=2, n_epochs=1, LAT=4, start at edge 10.
  -> a=0x00010000 at edge 11; update pulses at edge 15; a=0x00030000 at edge 16; update at edge 20; done at edge 21; epoch_cnt=1.
- Multi-epoch: n_samples=2, n_epochs=3.
  -> exactly 6 update pulses; sample_idx sequence 0,1,0,1,0,1; done at start+1+30 cycles; epoch_cnt=3.
- Zero and clamp: n_epochs=0 -> done one cycle after start, no update pulses. n_samples=7 with DEPTH=4 -> 4 samples per epoch.
- Ignored inputs: start and wr_en pulsed while busy.
  -> no restart, buffer contents unchanged (verify by re-reading in the next run), update count unchanged.
- Reset mid-run: drive reset=0 for 1 cycle during SETTLE of sample 1.
  -> next cycle all outputs are 0, busy=0, no done. A subsequent start runs normally from sample 0.
- LAT=1: n_samples=1, n_epochs=2.
  -> updates at start+2 and start+4; done at start+5.

Source files
------------

// File: rtl/train_sequencer_pkg.sv
// Shared types for the perceptron training sequencer: data width, FSM
// encoding and the packed layout of one stored training sample.
package train_sequencer_pkg;

    localparam int DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // a occupies the top word, target the bottom word
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] target;
    } sample_t;

    localparam int SW = $bits(sample_t);

endpackage

// File: rtl/train_sequencer_sample_mem.sv
// Training-set register file: one synchronous write port, one combinational
// read port. Contents survive reset on purpose so a loaded set can be rerun.
module train_sequencer_sample_mem
    import train_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  sample_t       wr_data,
    input  logic [AW-1:0] rd_addr,
    output sample_t       rd_data
);

    sample_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/train_sequencer.sv
// Streams the stored training set into the 2-3-1 perceptron datapath for a
// programmed number of epochs, strobing update once per sample.
//
// state  | meaning
// IDLE   | waiting for start; sample buffer writable
// LOAD   | present mem[sample_idx] on a/b/target, arm settle counter
// SETTLE | hold the sample while forward/backprop paths settle
// UPDATE | raise update, advance sample/epoch bookkeeping
// DONE   | pulse done, drop busy
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int LAT     = 4,
    parameter int EPOCH_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_a,
    input  logic [DW-1:0]      wr_b,
    input  logic [DW-1:0]      wr_target,
    input  logic [AW:0]        n_samples,
    input  logic [EPOCH_W-1:0] n_epochs,
    input  logic [DW-1:0]      step_in,
    input  logic               start,
    output logic [DW-1:0]      a,
    output logic [DW-1:0]      b,
    output logic [DW-1:0]      target,
    output logic [DW-1:0]      step,
    output logic               update,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      sample_idx,
    output logic [EPOCH_W-1:0] epoch_cnt
);

    localparam int              CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(LAT - 1);
    localparam logic [AW:0]     DEPTH_N  = (AW + 1)'(DEPTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [AW:0]        n_lat;
    logic [EPOCH_W-1:0] e_lat;
    logic               done_pend;
    logic [AW:0]        n_clamped;
    logic [AW:0]        last_idx;
    logic [EPOCH_W-1:0] epoch_next;
    logic               mem_we;
    sample_t            wr_data;
    sample_t            rd_data;

    assign n_clamped  = (n_samples > DEPTH_N) ? DEPTH_N : n_samples;
    assign last_idx   = n_lat - (AW + 1)'(1);
    assign epoch_next = epoch_cnt + EPOCH_W'(1);

    // reset dominates a coincident write so a held-in-reset block is inert
    assign mem_we  = wr_en && reset && (state == ST_IDLE);
    assign wr_data = '{a: wr_a, b: wr_b, target: wr_target};

    train_sequencer_sample_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sample_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (sample_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            n_lat      <= '0;
            e_lat      <= '0;
            done_pend  <= 1'b0;
            a          <= '0;
            b          <= '0;
            target     <= '0;
            step       <= '0;
            update     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_idx <= '0;
            epoch_cnt  <= '0;
        end else begin
            update    <= 1'b0;
            done      <= done_pend;
            done_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_lat      <= n_clamped;
                        e_lat      <= n_epochs;
                        step       <= step_in;
                        sample_idx <= '0;
                        epoch_cnt  <= '0;
                        // an empty run still reports completion, one cycle later
                        if (n_clamped == '0 || n_epochs == '0) begin
                            done_pend <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    a      <= rd_data.a;
                    b      <= rd_data.b;
                    target <= rd_data.target;
                    cnt    <= CNT_INIT;
                    state  <= (LAT == 1) ? ST_UPDATE : ST_SETTLE;
                end
                ST_SETTLE: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    update <= 1'b1;
                    if ({1'b0, sample_idx} == last_idx) begin
                        sample_idx <= '0;
                        epoch_cnt  <= epoch_next;
                        state      <= (epoch_next == e_lat) ? ST_DONE : ST_LOAD;
                    end else begin
                        sample_idx <= sample_idx + AW'(1);
                        state      <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
